wide_add_sequencer: RTL and testbench

- Multi-precision add/subtract controller.
- Processes a WIDE_WIDTH operand pair one CHUNK_WIDTH slice per cycle, least-significant chunk first.
- Uses a single internal carry_skip_adder instance (BIT_WIDTH = CHUNK_WIDTH) and carries between chunks through a carry register.
- Sits between a requester (valid/ready request side) and a consumer (valid/ready result side). Wide arithmetic costs CHUNK_NUM cycles instead of a WIDE_WIDTH-bit adder.

---
 rtl/wide_add_sequencer.sv | 118 +++++++++++
 tb/tb_wide_add_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wide_add_sequencer.sv
// Multi-precision add/subtract sequencer: walks a WIDE_WIDTH operand pair through one
// CHUNK_WIDTH carry-skip adder, least-significant chunk first, carrying through a register.
module wide_add_sequencer #(
  parameter  int CHUNK_WIDTH = 32,
  parameter  int CHUNK_NUM   = 4,
  localparam int WIDE_WIDTH  = CHUNK_WIDTH * CHUNK_NUM
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_valid_i,
  output logic                  start_ready_o,
  input  logic [WIDE_WIDTH-1:0] operand1_i,
  input  logic [WIDE_WIDTH-1:0] operand2_i,
  input  logic                  carry_i,
  input  logic                  sub_i,
  output logic                  result_valid_o,
  input  logic                  result_ready_i,
  output logic [WIDE_WIDTH-1:0] sum_o,
  output logic                  carry_o,
  output logic                  overflow_o,
  output logic                  busy_o
);

  localparam int            KW     = $clog2(CHUNK_NUM);
  localparam logic [KW-1:0] K_LAST = KW'(CHUNK_NUM - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [WIDE_WIDTH-1:0]   op1_q, op2_q, sum_q;
  logic                    carry_q, sub_q, carry_out_q, ovf_q;
  logic [KW-1:0]           k_q;
  logic [CHUNK_WIDTH-1:0]  add_a, add_b, add_sum;
  logic                    add_cout;
  logic                    accept, last_chunk;

  assign accept     = (state_q == IDLE) && start_valid_i;
  assign last_chunk = (k_q == K_LAST);
  assign add_a      = op1_q[k_q*CHUNK_WIDTH +: CHUNK_WIDTH];
  assign add_b      = op2_q[k_q*CHUNK_WIDTH +: CHUNK_WIDTH];

  // Carry-skip adder: 4-bit ripple blocks; a fully propagating block forwards its carry-in.
  always_comb begin : carry_skip_adder
    logic       c;
    logic [4:0] blk;
    c       = carry_q;
    blk     = '0;
    add_sum = '0;
    for (int b = 0; b < CHUNK_WIDTH / 4; b++) begin
      blk                = {1'b0, add_a[4*b +: 4]} + {1'b0, add_b[4*b +: 4]} + {4'b0, c};
      add_sum[4*b +: 4]  = blk[3:0];
      c                  = (&(add_a[4*b +: 4] ^ add_b[4*b +: 4])) ? c : blk[4];
    end
    add_cout = c;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    start_ready_o  = 1'b0;
    busy_o         = 1'b0;
    result_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        start_ready_o = 1'b1;
        if (start_valid_i) state_d = RUN;
      end
      RUN: begin
        busy_o = 1'b1;
        if (last_chunk) state_d = DONE;
      end
      DONE: begin
        result_valid_o = 1'b1;
        if (result_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Subtraction runs as op1 + ~op2 + ~borrow; the final carry is inverted back into a borrow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op1_q       <= '0;
      op2_q       <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      sub_q       <= 1'b0;
      carry_out_q <= 1'b0;
      ovf_q       <= 1'b0;
      k_q         <= '0;
    end else if (accept) begin
      op1_q   <= operand1_i;
      op2_q   <= sub_i ? ~operand2_i : operand2_i;
      carry_q <= carry_i ^ sub_i;
      sub_q   <= sub_i;
      k_q     <= '0;
    end else if (state_q == RUN) begin
      sum_q[k_q*CHUNK_WIDTH +: CHUNK_WIDTH] <= add_sum;
      carry_q <= add_cout;
      if (last_chunk) begin
        carry_out_q <= add_cout ^ sub_q;
        ovf_q       <= (op1_q[WIDE_WIDTH-1] == op2_q[WIDE_WIDTH-1]) &&
                       (add_sum[CHUNK_WIDTH-1] != op1_q[WIDE_WIDTH-1]);
      end else begin
        k_q <= k_q + KW'(1);
      end
    end
  end

  assign sum_o      = sum_q;
  assign carry_o    = carry_out_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Bench for wide_add_sequencer: directed literal cases plus free-running random traffic
// checked every cycle against an arithmetic reference model.
module tb_wide_add_sequencer;
  localparam int CW = 32;
  localparam int CN = 4;
  localparam int W  = CW * CN;

  localparam logic [W-1:0] ONES = '1;
  localparam logic [W-1:0] MAXP = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MINN = {1'b1, {(W-1){1'b0}}};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [W-1:0] operand1 = '0;
  logic [W-1:0] operand2 = '0;
  logic         carry_in = 1'b0;
  logic         sub = 1'b0;
  logic         result_valid;
  logic         result_ready = 1'b0;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         overflow;
  logic         busy;

  int vectors = 0;
  int miscompares = 0;

  wide_add_sequencer #(.CHUNK_WIDTH(CW), .CHUNK_NUM(CN)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .start_valid_i(start_valid), .start_ready_o(start_ready),
    .operand1_i(operand1), .operand2_i(operand2),
    .carry_i(carry_in), .sub_i(sub),
    .result_valid_o(result_valid), .result_ready_i(result_ready),
    .sum_o(sum), .carry_o(carry_out), .overflow_o(overflow), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // Reference arithmetic on full-width integers, independent of any chunking.
  function automatic void ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c, input logic s,
                                 output logic [W-1:0] r, output logic co, output logic ov);
    logic [W:0]          full;
    logic signed [W+1:0] sa, sb, sc, sr, mx, mn;
    sa = $signed({{2{a[W-1]}}, a});
    sb = $signed({{2{b[W-1]}}, b});
    sc = $signed((W+2)'(c));
    mx = $signed({3'b000, {(W-1){1'b1}}});
    mn = $signed({3'b111, {(W-1){1'b0}}});
    if (!s) begin
      full = {1'b0, a} + {1'b0, b} + (W+1)'(c);
      co   = full[W];
      sr   = sa + sb + sc;
    end else begin
      full = {1'b0, a} - {1'b0, b} - (W+1)'(c);
      co   = ({1'b0, a} < ({1'b0, b} + (W+1)'(c)));
      sr   = sa - sb - sc;
    end
    r  = full[W-1:0];
    ov = (sr > mx) || (sr < mn);
  endfunction

  // Transaction-level model: idle, CN cycles of work, then a held result until consumed.
  int           ph = 0;
  logic [W-1:0] e_sum = '0;
  logic         e_c = 1'b0;
  logic         e_ov = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = 0; e_sum = '0; e_c = 1'b0; e_ov = 1'b0;
    end else if (ph == 0) begin
      if (start_valid) begin
        ph = 1;
        ref_op(operand1, operand2, carry_in, sub, e_sum, e_c, e_ov);
      end
    end else if (ph <= CN) begin
      ph = ph + 1;
    end else if (result_ready) begin
      ph = 0;
    end
  end

  always @(negedge clk) begin
    chk("start_ready", start_ready, ph == 0);
    chk("busy", busy, (ph >= 1) && (ph <= CN));
    chk("result_valid", result_valid, ph == CN + 1);
    if (ph == 0 || ph == CN + 1) begin
      chk("sum", sum, e_sum);
      chk("carry", carry_out, e_c);
      chk("overflow", overflow, e_ov);
    end
  end

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] v;
    case ($urandom_range(0, 6))
      0: v = '0;
      1: v = ONES;
      2: v = MAXP;
      3: v = MINN;
      4: v = ONES ^ (W'(1) << $urandom_range(0, W-1));
      default: v = {$urandom, $urandom, $urandom, $urandom};
    endcase
    return v;
  endfunction

  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s);
    @(negedge clk);
    operand1 = a; operand2 = b; carry_in = c; sub = s; start_valid = 1'b1;
    for (int n = 0; n < 50 && !start_ready; n++) @(negedge clk);
    chk("accept_ready", start_ready, 1'b1);
    @(posedge clk); #1;
    start_valid = 1'b0;
    operand1 = rand_op(); operand2 = rand_op(); carry_in = 1'($urandom); sub = 1'($urandom);
  endtask

  task automatic wait_valid(output int edges);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!result_valid && n < 30);
    chk("valid_timeout", result_valid, 1'b1);
    edges = n - 1;
  endtask

  task automatic consume();
    @(negedge clk);
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
  endtask

  task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic s,
                          input logic [W-1:0] x_sum, input logic x_c, input logic x_ov);
    int edges;
    accept(a, b, c, s);
    wait_valid(edges);
    chk({name, "_latency"}, edges, CN);
    chk({name, "_sum"}, sum, x_sum);
    chk({name, "_carry"}, carry_out, x_c);
    chk({name, "_ovf"}, overflow, x_ov);
    consume();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t got=timeout expected=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    logic [W-1:0] held;
    repeat (3) @(negedge clk);
    chk("rst_valid", result_valid, 1'b0);
    chk("rst_ready", start_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sum", sum, '0);
    chk("rst_carry", carry_out, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    rst_n = 1'b1;

    directed("add_ripple", ONES, '0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    directed("sub_neg1", '0, W'(1), 1'b0, 1'b1, ONES, 1'b1, 1'b0);
    directed("add_ovf", MAXP, W'(1), 1'b0, 1'b0, MINN, 1'b0, 1'b1);
    directed("sub_ovf", MINN, W'(1), 1'b0, 1'b1, MAXP, 1'b0, 1'b1);

    // Backpressure with start_valid toggling in DONE.
    accept(W'(5), W'(7), 1'b0, 1'b0);
    wait_valid(edges);
    held = sum;
    for (int i = 0; i < 10; i++) begin
      start_valid = ~start_valid;
      operand1 = rand_op(); operand2 = rand_op();
      @(negedge clk);
      chk("bp_ready", start_ready, 1'b0);
      chk("bp_sum", sum, W'(12));
      chk("bp_stable", sum, held);
    end
    start_valid = 1'b0;
    consume();
    @(negedge clk);
    chk("bp_idle_ready", start_ready, 1'b1);
    directed("post_bp", W'(3), W'(4), 1'b0, 1'b0, W'(7), 1'b0, 1'b0);

    // Asynchronous reset at chunk 2 of a running operation.
    accept(128'h0123456789abcdef_0123456789abcdef, W'(1), 1'b0, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    chk("mid_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", result_valid, 1'b0);
    chk("mid_rst_ready", start_ready, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_sum", sum, '0);
    chk("mid_rst_carry", carry_out, 1'b0);
    chk("mid_rst_ovf", overflow, 1'b0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    directed("after_rst", 128'h1_0000_0000, 128'hFFFF_FFFF, 1'b0, 1'b0,
             128'h1_FFFF_FFFF, 1'b0, 1'b0);

    // Free-running random traffic with occasional asynchronous reset pulses.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start_valid  = ($urandom_range(0, 1) == 1);
      operand1     = rand_op();
      operand2     = rand_op();
      carry_in     = 1'($urandom);
      sub          = 1'($urandom);
      result_ready = ($urandom_range(0, 4) < 3);
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
    end
    start_valid = 1'b0;
    result_ready = 1'b1;
    repeat (CN + 3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
